// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the F->D pipeline register.
// Keeps the fetch PC, issues one instruction-memory request at a time,
// drops responses made stale by an execute redirect, and feeds the
// decode register under stall/bubble control from the hazard unit.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        execute_i_need_jump,
  input  logic [31:0] execute_jump_pc,
  input  logic        regD_stall,
  input  logic        regD_bubble,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output logic        decode_valid,
  output logic [31:0] decode_pc,
  output logic [31:0] decode_inst
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  fetch_pkt_t  hold_q, hold_d;

  logic        dec_valid_q, dec_valid_d;
  logic [31:0] dec_pc_q, dec_pc_d;
  logic [31:0] dec_inst_q, dec_inst_d;

  // Instruction handed to the decode register this cycle, if any.
  logic        deliver;
  fetch_pkt_t  deliver_pkt;

  logic        may_load;
  logic        redirect;

  assign may_load = !regD_stall && !regD_bubble;
  assign redirect = execute_i_need_jump;

  // Request side decodes straight from state and pc; nothing goes out in reset.
  assign imem_req_valid = rst_n && (state_q == S_REQ);
  assign imem_req_addr  = pc_q;

  // Fetch FSM next-state: PC advance, redirect handling, stale-response kill.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    kill_d      = kill_q;
    hold_d      = hold_q;
    deliver     = 1'b0;
    deliver_pkt = '{pc: req_pc_q, inst: imem_resp_inst};

    unique case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
          // The request that just went out belongs to the old path.
          if (redirect) kill_d = 1'b1;
        end
        if (redirect) pc_d = execute_jump_pc;
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          state_d = S_REQ;
          if (redirect || kill_q) begin
            kill_d = 1'b0;
          end else if (may_load) begin
            deliver = 1'b1;
          end else begin
            // Decode cannot take it now; park it instead of losing it.
            hold_d  = '{pc: req_pc_q, inst: imem_resp_inst};
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
        if (redirect) pc_d = execute_jump_pc;
      end

      S_HOLD: begin
        deliver_pkt = hold_q;
        if (redirect) begin
          pc_d    = execute_jump_pc;
          state_d = S_REQ;
        end else if (may_load) begin
          deliver = 1'b1;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Decode register: bubble beats stall, stall beats a new load.
  always_comb begin
    dec_valid_d = dec_valid_q;
    dec_pc_d    = dec_pc_q;
    dec_inst_d  = dec_inst_q;
    if (regD_bubble) begin
      dec_valid_d = 1'b0;
      dec_pc_d    = 32'd0;
      dec_inst_d  = NOP_INST;
    end else if (regD_stall) begin
      dec_valid_d = dec_valid_q;
    end else if (deliver) begin
      dec_valid_d = 1'b1;
      dec_pc_d    = deliver_pkt.pc;
      dec_inst_d  = deliver_pkt.inst;
    end else begin
      // Decode consumed its instruction; keep pc/inst for visibility.
      dec_valid_d = 1'b0;
    end
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      kill_q      <= 1'b0;
      hold_q      <= '0;
      dec_valid_q <= 1'b0;
      dec_pc_q    <= 32'd0;
      dec_inst_q  <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      hold_q      <= hold_d;
      dec_valid_q <= dec_valid_d;
      dec_pc_q    <= dec_pc_d;
      dec_inst_q  <= dec_inst_d;
    end
  end

  assign decode_valid = dec_valid_q;
  assign decode_pc    = dec_pc_q;
  assign decode_inst  = dec_inst_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction-memory model
// (inst = addr ^ 32'hFFFF, programmable response latency).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jmp;
  logic [31:0] jmp_pc;
  logic        stall, bubble;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        dvld;
  logic [31:0] dpc, dinst;

  int total = 0;
  int bad   = 0;
  int lat   = 1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .execute_i_need_jump (jmp),
    .execute_jump_pc     (jmp_pc),
    .regD_stall          (stall),
    .regD_bubble         (bubble),
    .imem_req_valid      (req_valid),
    .imem_req_ready      (req_ready),
    .imem_req_addr       (req_addr),
    .imem_resp_valid     (resp_valid),
    .imem_resp_inst      (resp_inst),
    .decode_valid        (dvld),
    .decode_pc           (dpc),
    .decode_inst         (dinst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Memory model: evaluated on the falling edge, where DUT outputs and
  // bench stimulus are both stable for the coming rising edge.
  logic        pend = 1'b0;
  int          cnt  = 0;
  logic [31:0] paddr = '0;
  initial begin
    resp_valid = 1'b0;
    resp_inst  = '0;
    forever begin
      @(negedge clk);
      resp_valid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          resp_valid = 1'b1;
          resp_inst  = paddr ^ 32'h0000_FFFF;
          pend       = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (req_valid && req_ready) begin
        pend  = 1'b1;
        paddr = req_addr;
        cnt   = lat;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=%0d exp=%0d", 1, 0);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; jmp = 1'b0; jmp_pc = '0;
    stall = 1'b0; bubble = 1'b0; req_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_valid", dvld, 0);
    chk("rst_pc", dpc, 0);
    chk("rst_inst", dinst, NOP);
    chk("rst_reqv", req_valid, 0);
    rst_n = 1'b1; #1;
    chk("first_reqv", req_valid, 1);
    chk("first_addr", req_addr, 32'h8000_0000);

    // Streaming: one instruction every 2 cycles
    tick();                                 // E1 accept 0000
    chk("s_wait_reqv", req_valid, 0);
    tick();                                 // E2 deliver 0000
    chk("s0_valid", dvld, 1);
    chk("s0_pc", dpc, 32'h8000_0000);
    chk("s0_inst", dinst, 32'h8000_FFFF);
    chk("s0_next_addr", req_addr, 32'h8000_0004);
    tick();                                 // E3
    chk("s_gap_valid", dvld, 0);
    tick();                                 // E4
    chk("s1_valid", dvld, 1);
    chk("s1_pc", dpc, 32'h8000_0004);
    chk("s1_inst", dinst, 32'h8000_FFFB);
    tick(); tick();                         // E6
    chk("s2_pc", dpc, 32'h8000_0008);
    chk("s2_inst", dinst, 32'h8000_FFF7);

    // Stall while the 0004 response arrives -> HOLD, then drain
    do_reset();
    tick(); tick();                         // 0000 in decode
    stall = 1'b1;
    tick(); tick(); tick();                 // E3..E5 stalled
    chk("st_keep_pc", dpc, 32'h8000_0000);
    chk("st_keep_valid", dvld, 1);
    chk("st_hold_reqv", req_valid, 0);
    stall = 1'b0;
    tick();                                 // drain hold buffer
    chk("st_drain_pc", dpc, 32'h8000_0004);
    chk("st_drain_inst", dinst, 32'h8000_FFFB);
    chk("st_drain_valid", dvld, 1);
    chk("st_next_reqv", req_valid, 1);
    chk("st_next_addr", req_addr, 32'h8000_0008);

    // Redirect while waiting; response comes 2 cycles after acceptance
    lat = 2;
    tick();                                 // accept 0008
    jmp = 1'b1; jmp_pc = 32'h8000_0100;
    tick();                                 // WAIT, no resp -> kill
    jmp = 1'b0;
    chk("rw_reqv", req_valid, 0);
    tick();                                 // stale resp discarded
    chk("rw_valid", dvld, 0);
    chk("rw_reqv2", req_valid, 1);
    chk("rw_addr", req_addr, 32'h8000_0100);
    lat = 1;
    tick(); tick();
    chk("rw_tgt_pc", dpc, 32'h8000_0100);
    chk("rw_tgt_inst", dinst, 32'h8000_FEFF);

    // Redirect in the same cycle as the handshake for 0008
    do_reset();
    tick(); tick(); tick(); tick();         // 0004 in decode, REQ at 0008
    chk("rh_pre_addr", req_addr, 32'h8000_0008);
    jmp = 1'b1; jmp_pc = 32'h8000_0200;
    tick();                                 // accepted + redirected
    jmp = 1'b0;
    chk("rh_wait_reqv", req_valid, 0);
    tick();                                 // 0008 response dropped
    chk("rh_drop_valid", dvld, 0);
    chk("rh_drop_pc", dpc, 32'h8000_0004);
    chk("rh_addr", req_addr, 32'h8000_0200);
    tick(); tick();
    chk("rh_tgt_valid", dvld, 1);
    chk("rh_tgt_pc", dpc, 32'h8000_0200);
    chk("rh_tgt_inst", dinst, 32'h8000_FDFF);

    // Bubble and stall together flush a live decode entry
    stall = 1'b1; bubble = 1'b1;
    tick();
    stall = 1'b0; bubble = 1'b0;
    chk("bb_valid", dvld, 0);
    chk("bb_pc", dpc, 0);
    chk("bb_inst", dinst, NOP);
    tick();                                 // 0204 still delivered
    chk("bb_next_pc", dpc, 32'h8000_0204);
    chk("bb_next_valid", dvld, 1);

    // Reset during WAIT; stale response arrives in REQ and is ignored
    lat = 2;
    tick();                                 // accept 0208
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    chk("rr_valid", dvld, 0);
    chk("rr_addr", req_addr, 32'h8000_0000);
    tick();                                 // stale resp in REQ; accept 0000
    chk("rr_ign_valid", dvld, 0);
    chk("rr_ign_reqv", req_valid, 0);
    tick(); tick();
    chk("rr_restart_valid", dvld, 1);
    chk("rr_restart_pc", dpc, 32'h8000_0000);
    chk("rr_restart_inst", dinst, 32'h8000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
